// File: rtl/dds_pkg.sv
// Shared definitions for the DDS control blocks.
//   DDS_W   default phase-step width (must match the downstream DDS)
//   DDS_CW  default dwell counter width
//   sweep_state_e  sweep controller state encoding
package dds_pkg;

  localparam int DDS_W  = 12;
  localparam int DDS_CW = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/dds_dwell_timer.sv
// Dwell timer: counts cycles from zero and flags when the count reaches the
// programmed dwell value, then wraps to zero. One expire pulse therefore
// occurs every dwell+1 cycles while clear is low.
//   clk     primary clock
//   reset   synchronous reset, active-high (count -> 0)
//   clear   holds the count at zero (idle / restart)
//   dwell   terminal count
//   expire  high in the cycle where count == dwell
module dds_dwell_timer
  import dds_pkg::*;
#(
  parameter int CW = DDS_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic [CW-1:0] dwell,
  output logic          expire
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] count;

  assign expire = (count == dwell);

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (expire) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep (chirp) controller feeding the DDS phase-step input.
// Produces a staircase from f_start to f_stop in f_inc increments, each step
// held dwell+1 cycles. Mode 0 sweeps once and pulses done; mode 1 bounces
// between the two endpoints until aborted.
//   clk       primary clock
//   reset     synchronous reset, active-high
//   start     one-cycle pulse, starts a sweep when idle
//   abort     one-cycle pulse, ends any sweep (wins over start)
//   mode      0 = single sweep, 1 = continuous triangle
//   f_start   first phase step
//   f_stop    final phase step
//   f_inc     phase-step increment magnitude
//   dwell     each step is held dwell+1 cycles
//   step_out  registered phase step to the DDS
//   busy      high while sweeping
//   done      one-cycle pulse when a single sweep completes
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int W  = DDS_W,
  parameter int CW = DDS_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          mode,
  input  logic [W-1:0]  f_start,
  input  logic [W-1:0]  f_stop,
  input  logic [W-1:0]  f_inc,
  input  logic [CW-1:0] dwell,
  output logic [W-1:0]  step_out,
  output logic          busy,
  output logic          done
);

  sweep_state_e  state;

  // Configuration captured on an accepted start.
  logic [W-1:0]  f_start_q;
  logic [W-1:0]  f_stop_q;
  logic [W-1:0]  f_inc_q;
  logic [CW-1:0] dwell_q;
  logic          mode_q;
  logic          degen_q;   // f_start == f_stop or f_inc == 0

  // Current leg of the sweep.
  logic          up_q;      // 1 = stepping upward
  logic [W-1:0]  target_q;  // endpoint of the current leg

  logic          expire;
  logic          at_end;
  logic [W-1:0]  fwd_step;
  logic [W-1:0]  rev_step;
  logic [W-1:0]  rev_target;

  // Next step toward target, clamped so it never passes (or wraps around)
  // the endpoint. The extra MSB catches carry-out and borrow.
  function automatic logic [W-1:0] advance(
    input logic [W-1:0] step,
    input logic [W-1:0] inc,
    input logic [W-1:0] target,
    input logic         up
  );
    logic [W:0] sum;
    logic [W:0] diff;
    sum  = {1'b0, step} + {1'b0, inc};
    diff = {1'b0, step} - {1'b0, inc};
    if (up) begin
      advance = (sum >= {1'b0, target}) ? target : sum[W-1:0];
    end else begin
      advance = (diff[W] || (diff[W-1:0] <= target)) ? target : diff[W-1:0];
    end
  endfunction

  // The timer sits at zero whenever no sweep is running and is cleared by
  // abort so a following start always begins a full dwell.
  dds_dwell_timer #(
    .CW (CW)
  ) u_dwell_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  ((state == IDLE) || abort),
    .dwell  (dwell_q),
    .expire (expire)
  );

  // A degenerate sweep has no intermediate steps, so its first dwell expiry
  // is already the endpoint.
  assign at_end     = expire && ((step_out == target_q) || degen_q);
  assign fwd_step   = advance(step_out, f_inc_q, target_q, up_q);
  // At a reversal the endpoint has already been held for a full dwell, so
  // the step moves straight off it in the new direction.
  assign rev_target = (target_q == f_stop_q) ? f_start_q : f_stop_q;
  assign rev_step   = advance(step_out, f_inc_q, rev_target, !up_q);

  // NOTE: the configuration registers are intentionally left out of reset;
  // they are only read while sweeping and are always loaded by a start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      step_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              f_start_q <= f_start;
              f_stop_q  <= f_stop;
              f_inc_q   <= f_inc;
              dwell_q   <= dwell;
              mode_q    <= mode;
              degen_q   <= (f_start == f_stop) || (f_inc == '0);
              up_q      <= (f_stop >= f_start);
              target_q  <= f_stop;
              step_out  <= f_start;
              busy      <= 1'b1;
              state     <= SWEEP;
            end
          end

          SWEEP: begin
            if (at_end) begin
              if (!mode_q) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else if (!degen_q) begin
                up_q     <= !up_q;
                target_q <= rev_target;
                step_out <= rev_step;
              end
            end else if (expire) begin
              step_out <= fwd_step;
            end
          end

          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Frequency-sweep (chirp) controller sitting directly upstream of the DDS phase accumulator. Drives the accumulator's W-bit phase-step input with a staircase of phase steps, from a start value to a stop value. Each step is held for a programmable dwell time. Supports a single sweep or a continuous triangle sweep. Has start/abort control plus busy/done status for the test or host sequencer.

Parameters:
W, 12, phase-step width; must match the downstream DDS width.
CW, 16, dwell counter width.

Ports:
clk  input  1  primary clock
reset  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; begins a sweep when idle
abort  input  1  one-cycle pulse; ends any sweep
mode  input  1  0 = single sweep, 1 = continuous triangle
f_start  input  W  first phase step
f_stop  input  W  final phase step (sweep endpoint)
f_inc  input  W  phase-step increment magnitude
dwell  input  CW  each step is held for dwell+1 cycles
step_out  output  W  phase step to the DDS din input (registered)
busy  output  1  high while sweeping
done  output  1  one-cycle pulse when a single sweep completes

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: step_out=0, busy=0, done=0, state=IDLE, dwell counter=0. Reset mid-sweep returns to these values on the next edge.
- States: IDLE, SWEEP.
- Configuration: f_start, f_stop, f_inc, dwell and mode are latched on an accepted start. Input changes during a sweep are ignored.
- Direction is latched at start: up if f_stop >= f_start, else down. The target register is loaded with f_stop.
- IDLE, start=1 (edge N): at N+1, step_out=f_start, busy=1, dwell counter cleared, state=SWEEP.
- Degenerate start (f_start==f_stop or f_inc==0): step_out=f_start is held dwell+1 cycles, then the sweep completes as at an endpoint. In mode 1 it holds until abort.
- SWEEP: the dwell counter increments every cycle. When the counter equals dwell, the counter clears and the step advances.
- Up: next = step_out + f_inc, computed in W+1 bits. If next >= target, step_out=target (clamped, no wrap).
- Down: next = step_out - f_inc, computed in W+1 bits signed. If next <= target or it underflows, step_out=target.
- Endpoint: dwell expires while step_out==target.
  - Mode 0: state=IDLE, busy=0, done=1 for exactly one cycle; step_out holds the endpoint value.
  - Mode 1: direction inverts, target swaps between latched f_start and f_stop, sweeping continues, done never pulses.
- Each endpoint value is held exactly dwell+1 cycles; it is not repeated at a reversal.
- IDLE holds step_out at its last value (0 after reset). The DDS keeps running at that rate.
- abort (any state): next edge state=IDLE, busy=0, done=0, step_out unchanged.
- Simultaneous abort and start: abort wins and start is ignored.
- start while busy is ignored.
- reset has priority over everything.

Decomposition:
- Shared package dds_pkg:
  - state enum for IDLE/SWEEP
  - default phase width constant DDS_W=12
  - dwell width constant DDS_CW=16
- Sub-module dds_dwell_timer:
  - inputs: clk, reset, clear, dwell
  - output: expire pulse when count==dwell
  - also reusable by later DDS modulation blocks.
- Step arithmetic and clamping stay in dds_sweep_ctrl.

Test Plan:
- Up sweep, mode 0, f_start=0x020, f_stop=0x040, f_inc=0x010, dwell=2 -> step_out 0x020, 0x030, 0x040, each for 3 cycles; then done=1 for one cycle with busy=0, and step_out stays 0x040.
- Clamp and no wrap: f_start=0xFF0, f_stop=0xFFF, f_inc=0x020, dwell=0 -> step_out 0xFF0, then 0xFFF, then done; never 0x010. Also f_start=0x020, f_stop=0x035, f_inc=0x010 -> 0x020, 0x030, 0x035.
- Down sweep: f_start=0x200, f_stop=0x0D0, f_inc=0x080, dwell=1 -> 0x200, 0x180, 0x100, 0x0D0, each for 2 cycles, then done.
- Continuous: mode=1, 0x020->0x040, f_inc=0x010, dwell=0 -> 0x020, 0x030, 0x040, 0x030, 0x020, 0x030, ...; done stays 0. Abort -> busy=0 next cycle and step_out frozen.
- Control corners: start while busy ignored; abort and start in the same cycle -> stays IDLE; f_inc=0 in mode 0 -> f_start held dwell+1 cycles, then done.
- Reset mid-sweep at step 0x030 -> next cycle step_out=0, busy=0, done=0. A fresh start then sweeps normally.
- Bench integration: drive dds din from step_out and check that the accumulator increments by the current step_out every cycle after reset deasserts.
